// File: rtl/conv_pkg.sv
// Shared constants and controller state encoding for the line buffer and the 3x3 convolver.
package conv_pkg;

    localparam int unsigned NB_PIXEL    = 8;
    localparam int unsigned KERNEL_SIZE = 9;

    typedef enum logic [1:0] {
        StIdle       = 2'd0,
        StKnlCapture = 2'd1,
        StKnlEmit    = 2'd2,
        StStream     = 2'd3
    } state_e;

endpackage

// File: rtl/line_ram.sv
// Single-port line store: one word per column holds {line_a, line_b}.
// The read is combinational, so a write on the same edge sees the old word (read-before-write).
module line_ram #(
    parameter int unsigned Depth = 640,
    parameter int unsigned Width = 16
) (
    input  logic                     clk,
    input  logic                     we_i,
    input  logic [$clog2(Depth)-1:0] addr_i,
    input  logic [Width-1:0]         wdata_i,
    output logic [Width-1:0]         rdata_o
);

    logic [Width-1:0] mem [Depth];

    assign rdata_o = mem[addr_i];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[addr_i] <= wdata_i;
        end
    end

endmodule

// File: rtl/conv_line_buffer.sv
// Two-line buffer feeding a 3x3 convolver one column per accepted pixel, plus a
// capture/emit path that loads a 3x3 kernel into the convolver column by column.
module conv_line_buffer
    import conv_pkg::KERNEL_SIZE, conv_pkg::state_e, conv_pkg::StIdle,
           conv_pkg::StKnlCapture, conv_pkg::StKnlEmit, conv_pkg::StStream;
#(
    parameter int unsigned IMG_WIDTH  = 640,
    parameter int unsigned IMG_HEIGHT = 480,
    parameter int unsigned NB_PIXEL   = conv_pkg::NB_PIXEL
) (
    input  logic                clk,
    input  logic                i_rst,
    input  logic                i_valid,
    input  logic                i_sof,
    input  logic [NB_PIXEL-1:0] i_pixel,
    input  logic                i_load_req,
    output logic                o_ready,
    output logic [NB_PIXEL-1:0] o_data1,
    output logic [NB_PIXEL-1:0] o_data2,
    output logic [NB_PIXEL-1:0] o_data3,
    output logic                o_en_conv,
    output logic                o_load_knl,
    output logic                o_win_valid
);

    localparam int unsigned CW = $clog2(IMG_WIDTH);
    localparam int unsigned RW = $clog2(IMG_HEIGHT);

    state_e              state_q;
    logic [RW-1:0]       row_q;
    logic [CW-1:0]       col_q;
    logic [3:0]          cap_q;
    logic [1:0]          emit_q;
    logic [NB_PIXEL-1:0] knl_q [KERNEL_SIZE];

    logic [NB_PIXEL-1:0] data1_q, data2_q, data3_q;
    logic                en_conv_q, load_knl_q, win_valid_q;

    logic                accept, restart, pix_we;
    logic [RW-1:0]       row_eff;
    logic [CW-1:0]       col_eff;
    logic [NB_PIXEL-1:0] rd_a, rd_b;
    logic [1:0]          emit_nxt;
    logic [3:0]          kidx;
    logic [NB_PIXEL-1:0] kc1, kc2, kc3;

    always_comb begin
        unique case (state_q)
            StIdle:       o_ready = !i_load_req;
            StKnlCapture: o_ready = 1'b1;
            StKnlEmit:    o_ready = 1'b0;
            default:      o_ready = 1'b1;
        endcase
    end

    assign accept  = i_valid && o_ready;
    // In IDLE only an SOF pixel starts a frame; in STREAM an SOF pixel restarts at (0,0).
    assign restart = i_sof || (state_q == StIdle);
    assign pix_we  = accept && ((state_q == StStream) || (state_q == StIdle && i_sof));
    assign row_eff = restart ? '0 : row_q;
    assign col_eff = restart ? '0 : col_q;

    line_ram #(
        .Depth (IMG_WIDTH),
        .Width (2 * NB_PIXEL)
    ) u_line_ram (
        .clk     (clk),
        .we_i    (pix_we),
        .addr_i  (col_eff),
        .wdata_i ({rd_b, i_pixel}),
        .rdata_o ({rd_a, rd_b})
    );

    // Kernel column to present on the next emit cycle; index 3 is the all-zero wrap column.
    assign emit_nxt = emit_q + 2'd1;
    assign kidx     = {2'b00, emit_nxt};

    always_comb begin
        kc1 = '0;
        kc2 = '0;
        kc3 = '0;
        if (emit_nxt != 2'd3) begin
            kc1 = knl_q[kidx];
            kc2 = knl_q[kidx + 4'd3];
            kc3 = knl_q[kidx + 4'd6];
        end
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            state_q     <= StIdle;
            row_q       <= '0;
            col_q       <= '0;
            cap_q       <= '0;
            emit_q      <= '0;
            for (int unsigned i = 0; i < KERNEL_SIZE; i++) begin
                knl_q[i] <= '0;
            end
            data1_q     <= '0;
            data2_q     <= '0;
            data3_q     <= '0;
            en_conv_q   <= 1'b0;
            load_knl_q  <= 1'b0;
            win_valid_q <= 1'b0;
        end else begin
            en_conv_q   <= 1'b0;
            load_knl_q  <= 1'b0;
            win_valid_q <= 1'b0;

            if (pix_we) begin
                en_conv_q   <= 1'b1;
                data1_q     <= (row_eff < RW'(2)) ? '0 : rd_a;
                data2_q     <= (row_eff < RW'(1)) ? '0 : rd_b;
                data3_q     <= i_pixel;
                win_valid_q <= (row_eff >= RW'(2)) && (col_eff >= CW'(2));
                state_q     <= StStream;
                if (col_eff == CW'(IMG_WIDTH - 1)) begin
                    col_q <= '0;
                    if (row_eff == RW'(IMG_HEIGHT - 1)) begin
                        row_q   <= '0;
                        state_q <= StIdle;
                    end else begin
                        row_q <= row_eff + RW'(1);
                    end
                end else begin
                    col_q <= col_eff + CW'(1);
                    row_q <= row_eff;
                end
            end

            unique case (state_q)
                StIdle: begin
                    if (i_load_req) begin
                        state_q <= StKnlCapture;
                        cap_q   <= '0;
                    end
                end
                StKnlCapture: begin
                    if (accept) begin
                        knl_q[cap_q] <= i_pixel;
                        if (cap_q == 4'(KERNEL_SIZE - 1)) begin
                            // Column 0 (k0,k3,k6) is already stored, so emission starts now.
                            state_q    <= StKnlEmit;
                            emit_q     <= '0;
                            load_knl_q <= 1'b1;
                            data1_q    <= knl_q[0];
                            data2_q    <= knl_q[3];
                            data3_q    <= knl_q[6];
                        end else begin
                            cap_q <= cap_q + 4'd1;
                        end
                    end
                end
                StKnlEmit: begin
                    if (emit_q != 2'd3) begin
                        load_knl_q <= 1'b1;
                        data1_q    <= kc1;
                        data2_q    <= kc2;
                        data3_q    <= kc3;
                        emit_q     <= emit_nxt;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_data1     = data1_q;
    assign o_data2     = data2_q;
    assign o_data3     = data3_q;
    assign o_en_conv   = en_conv_q;
    assign o_load_knl  = load_knl_q;
    assign o_win_valid = win_valid_q;

endmodule

// File: tb/tb_conv_line_buffer.sv
// Scoreboard bench for conv_line_buffer: a frame-image reference model predicts every
// column/kernel strobe, and an independent monitor pops and compares them.
module tb_conv_line_buffer;

    localparam int W  = 4;
    localparam int H  = 4;
    localparam int NB = 8;

    logic          clk = 1'b0;
    logic          i_rst, i_valid, i_sof, i_load_req;
    logic [NB-1:0] i_pixel;
    logic          o_ready, o_en_conv, o_load_knl, o_win_valid;
    logic [NB-1:0] o_data1, o_data2, o_data3;

    conv_line_buffer #(
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H),
        .NB_PIXEL   (NB)
    ) dut (
        .clk         (clk),
        .i_rst       (i_rst),
        .i_valid     (i_valid),
        .i_sof       (i_sof),
        .i_pixel     (i_pixel),
        .i_load_req  (i_load_req),
        .o_ready     (o_ready),
        .o_data1     (o_data1),
        .o_data2     (o_data2),
        .o_data3     (o_data3),
        .o_en_conv   (o_en_conv),
        .o_load_knl  (o_load_knl),
        .o_win_valid (o_win_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit            knl;
        logic [NB-1:0] d1, d2, d3;
        bit            win;
    } exp_t;

    typedef enum {MIdle, MCap, MEmit, MStream} mst_t;

    exp_t          q[$];
    int            n_checks = 0;
    int            n_pass   = 0;
    bit            mon_en   = 1'b0;

    mst_t          m_st = MIdle;
    int            m_r = 0, m_c = 0, m_emit = 0;
    logic [NB-1:0] m_k[$];
    logic [NB-1:0] img [H][W];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Expected column from the frame image: rows r-2, r-1, r at this column.
    task automatic model_pixel(input logic [NB-1:0] pix);
        exp_t e;
        e.knl = 1'b0;
        e.d1  = (m_r >= 2) ? img[m_r-2][m_c] : '0;
        e.d2  = (m_r >= 1) ? img[m_r-1][m_c] : '0;
        e.d3  = pix;
        e.win = (m_r >= 2) && (m_c >= 2);
        q.push_back(e);
        img[m_r][m_c] = pix;
        m_c++;
        if (m_c == W) begin
            m_c = 0;
            m_r++;
            if (m_r == H) begin
                m_r  = 0;
                m_st = MIdle;
            end
        end
    endtask

    task automatic push_kernel();
        exp_t e;
        for (int c = 0; c < 3; c++) begin
            e.knl = 1'b1; e.win = 1'b0;
            e.d1 = m_k[c]; e.d2 = m_k[3+c]; e.d3 = m_k[6+c];
            q.push_back(e);
        end
        e.knl = 1'b1; e.win = 1'b0; e.d1 = '0; e.d2 = '0; e.d3 = '0;
        q.push_back(e);
    endtask

    task automatic cycle(input bit rst, input bit valid, input bit sof,
                         input logic [NB-1:0] pix, input bit load);
        bit exp_ready, acc;
        @(posedge clk);
        #1;
        i_rst = rst; i_valid = valid; i_sof = sof; i_pixel = pix; i_load_req = load;
        case (m_st)
            MIdle:   exp_ready = !load;
            MEmit:   exp_ready = 1'b0;
            default: exp_ready = 1'b1;
        endcase
        acc = valid && exp_ready;
        @(negedge clk);
        chk("o_ready", o_ready, exp_ready);
        #1;
        if (rst) begin
            m_st = MIdle; m_r = 0; m_c = 0;
            q.delete();
            m_k.delete();
        end else begin
            case (m_st)
                MIdle: begin
                    if (load) begin
                        m_st = MCap;
                        m_k.delete();
                    end else if (acc && sof) begin
                        m_r = 0; m_c = 0; m_st = MStream;
                        model_pixel(pix);
                    end
                end
                MCap: begin
                    if (acc) begin
                        m_k.push_back(pix);
                        if (m_k.size() == 9) begin
                            push_kernel();
                            m_st = MEmit; m_emit = 4;
                        end
                    end
                end
                MEmit: begin
                    m_emit--;
                    if (m_emit == 0) m_st = MIdle;
                end
                MStream: begin
                    if (acc) begin
                        if (sof) begin m_r = 0; m_c = 0; end
                        model_pixel(pix);
                    end
                end
            endcase
        end
    endtask

    task automatic load_kernel(input bit random_bytes);
        cycle(0, 0, 0, 8'd0, 1);
        for (int b = 1; b <= 9; b++)
            cycle(0, 1, 0, random_bytes ? NB'($urandom) : NB'(b), 0);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (o_en_conv === 1'b1 || o_load_knl === 1'b1) begin
                exp_t e;
                chk("en_conv_and_load_knl", {31'd0, o_en_conv & o_load_knl}, 0);
                chk("output_expected", (q.size() == 0) ? 0 : 1, 1);
                if (q.size() != 0) begin
                    e = q.pop_front();
                    chk("strobe_kind", {31'd0, o_load_knl}, {31'd0, e.knl});
                    chk("o_data1", {24'd0, o_data1}, {24'd0, e.d1});
                    chk("o_data2", {24'd0, o_data2}, {24'd0, e.d2});
                    chk("o_data3", {24'd0, o_data3}, {24'd0, e.d3});
                    chk("o_win_valid", {31'd0, o_win_valid}, {31'd0, e.win});
                end
            end else begin
                chk("win_without_en", {31'd0, o_win_valid}, 0);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        i_rst = 1'b1; i_valid = 1'b0; i_sof = 1'b0; i_pixel = '0; i_load_req = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_o_ready", o_ready, 1);
        chk("reset_o_data1", o_data1, 0);
        chk("reset_o_data2", o_data2, 0);
        chk("reset_o_data3", o_data3, 0);
        chk("reset_o_en_conv", o_en_conv, 0);
        chk("reset_o_load_knl", o_load_knl, 0);
        chk("reset_o_win_valid", o_win_valid, 0);
        i_rst  = 1'b0;
        mon_en = 1'b1;

        // Kernel 1..9, pixels offered during emit must be refused.
        load_kernel(0);
        repeat (4) cycle(0, 1, 0, NB'($urandom), 0);
        repeat (2) cycle(0, 0, 0, 8'd0, 0);

        // Full contiguous frame.
        for (int p = 1; p <= 16; p++) cycle(0, 1, p == 1, NB'(p), 0);
        repeat (2) cycle(0, 0, 0, 8'd0, 0);

        // Gapped frame.
        for (int p = 1; p <= 16; p++) begin
            cycle(0, 1, p == 1, NB'(p), 0);
            cycle(0, 0, 0, NB'($urandom), 0);
        end

        // Restart on the 7th pixel, then finish that frame; load_req mid-stream is ignored.
        for (int p = 1; p <= 22; p++) cycle(0, 1, (p == 1) || (p == 7), NB'(p), p == 9);
        repeat (2) cycle(0, 0, 0, 8'd0, 0);

        // Non-SOF pixel in IDLE is discarded; load_req beats a concurrent SOF pixel.
        cycle(0, 1, 0, 8'h55, 0);
        cycle(0, 1, 1, 8'hAA, 1);
        for (int b = 0; b < 9; b++) cycle(0, 1, 0, NB'($urandom), 0);
        repeat (4) cycle(0, 0, 0, 8'd0, 0);

        // Reset during emit cycle 1, then a clean reload.
        load_kernel(1);
        cycle(0, 0, 0, 8'd0, 0);
        cycle(1, 0, 0, 8'd0, 0);
        cycle(0, 0, 0, 8'd0, 0);
        chk("post_reset_o_load_knl", o_load_knl, 0);
        chk("post_reset_o_data1", o_data1, 0);
        chk("post_reset_o_data2", o_data2, 0);
        chk("post_reset_o_data3", o_data3, 0);
        load_kernel(1);
        repeat (4) cycle(0, 0, 0, 8'd0, 0);

        // Randomised traffic across all states.
        repeat (900) begin
            cycle(($urandom % 250) == 0, ($urandom % 4) != 0, ($urandom % 16) == 0,
                  NB'($urandom), ($urandom % 12) == 0);
        end
        repeat (8) cycle(0, 0, 0, 8'd0, 0);
        chk("scoreboard_drained", q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
